div_ctrl: RTL and testbench

//  Multi-cycle divider controller for the EX stage (DIV/DIVU). Latches operands,

---
 rtl/div_ctrl.sv | 171 +++++++++++++++++
 tb/tb_div_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider controller for DIV/DIVU in the EX stage.
// Returns quotient (LO) and remainder (HI), stalling the pipeline until the result is ready.
module div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic             stallreq_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DZ   = 2'd1,
        S_ON   = 2'd2,
        S_END  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic             r_dvd_neg;
    logic             r_dvs_neg;
    logic             w_accept;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quo_next;

    // Two's-complement negation when cond is set, otherwise pass-through.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic cond);
        logic [WIDTH-1:0] res;
        if (cond) begin
            res = (~v) + ONE;
        end else begin
            res = v;
        end
        return res;
    endfunction

    assign w_accept = (r_state == S_IDLE) && start_i && !annul_i;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        w_shift    = {r_rem, r_quo[WIDTH-1]};
        w_ge       = (w_shift >= {1'b0, r_divisor});
        w_diff     = w_shift - {1'b0, r_divisor};
        w_quo_next = {r_quo[WIDTH-2:0], w_ge};
        if (w_ge) begin
            w_rem_next = w_diff[WIDTH-1:0];
        end else begin
            w_rem_next = w_shift[WIDTH-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; annul aborts any in-flight work except a finishing END.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (divisor_i == ZERO) ? S_DZ : S_ON;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_DZ: begin
                w_state_next = annul_i ? S_IDLE : S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    w_state_next = S_IDLE;
                end else if (r_cnt == LAST_CNT) begin
                    w_state_next = S_END;
                end else begin
                    w_state_next = S_ON;
                end
            end
            S_END:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Stall request drops in END so EX advances together with the ready pulse.
    always_comb begin
        case (r_state)
            S_IDLE:  stallreq_o = start_i && !annul_i;
            S_DZ:    stallreq_o = !annul_i;
            S_ON:    stallreq_o = !annul_i;
            default: stallreq_o = 1'b0;
        endcase
    end

    // Datapath; results are registered on entry to END so they are valid with ready_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= {CW{1'b0}};
            r_rem       <= ZERO;
            r_quo       <= ZERO;
            r_divisor   <= ZERO;
            r_dvd_neg   <= 1'b0;
            r_dvs_neg   <= 1'b0;
            ready_o     <= 1'b0;
            quotient_o  <= ZERO;
            remainder_o <= ZERO;
        end else begin
            ready_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_dvd_neg <= signed_i && dividend_i[WIDTH-1];
                        r_dvs_neg <= signed_i && divisor_i[WIDTH-1];
                        r_quo     <= neg_if(dividend_i, signed_i && dividend_i[WIDTH-1]);
                        r_divisor <= neg_if(divisor_i, signed_i && divisor_i[WIDTH-1]);
                        r_rem     <= ZERO;
                        r_cnt     <= {CW{1'b0}};
                    end
                end
                S_DZ: begin
                    if (!annul_i) begin
                        ready_o     <= 1'b1;
                        quotient_o  <= ZERO;
                        remainder_o <= ZERO;
                    end
                end
                S_ON: begin
                    if (!annul_i) begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_cnt == LAST_CNT) begin
                            ready_o     <= 1'b1;
                            quotient_o  <= neg_if(w_quo_next, r_dvd_neg ^ r_dvs_neg);
                            remainder_o <= neg_if(w_rem_next, r_dvd_neg);
                        end
                    end
                end
                default: begin
                    ready_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed corner cases plus randomized divisions
// checked against a magnitude/sign arithmetic reference model.
module tb_div_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic         signed_i;
    logic [W-1:0] dividend_i;
    logic [W-1:0] divisor_i;
    logic         annul_i;
    logic         stallreq_o;
    logic         ready_o;
    logic [W-1:0] quotient_o;
    logic [W-1:0] remainder_o;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] last_q = 32'd0;
    logic [W-1:0] last_r = 32'd0;

    div_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .annul_i     (annul_i),
        .stallreq_o  (stallreq_o),
        .ready_o     (ready_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    always #5 clk = ~clk;

    // Reference: divide magnitudes, then quotient negative on sign mismatch, remainder follows dividend.
    function automatic void model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint unsigned ma, mb, q64, r64, qs, rs;
        bit na, nb;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
            return;
        end
        na  = sg && a[W-1];
        nb  = sg && b[W-1];
        ma  = na ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
        mb  = nb ? (64'h1_0000_0000 - {32'd0, b}) : {32'd0, b};
        q64 = ma / mb;
        r64 = ma % mb;
        qs  = (na != nb) ? (64'h1_0000_0000 - q64) : q64;
        rs  = na ? (64'h1_0000_0000 - r64) : r64;
        q   = qs[W-1:0];
        r   = rs[W-1:0];
    endfunction

    // Issue one division as EX would: hold start_i until the cycle where ready_o is seen.
    // Cycle 0 is the IDLE cycle where start_i is first presented.
    task automatic run_div(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int lat, output int stalls, output logic [W-1:0] q,
                           output logic [W-1:0] r, output bit got);
        int n;
        @(negedge clk);
        start_i    = 1'b1;
        signed_i   = sg;
        dividend_i = a;
        divisor_i  = b;
        n = 0; stalls = 0; got = 1'b0; lat = -1; q = 32'd0; r = 32'd0;
        while (n < 100) begin
            #1;
            if (stallreq_o) stalls++;
            if (ready_o) begin
                got = 1'b1; lat = n; q = quotient_o; r = remainder_o;
                break;
            end
            @(negedge clk);
            n++;
            dividend_i = $urandom;
            divisor_i  = $urandom;
            signed_i   = $urandom_range(0, 1);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
        dividend_i = 32'd0; divisor_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", ready_o); end
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stallreq_o); end
        checks++; if (quotient_o !== 32'd0) begin failures++; $display("FAIL reset_quo: got %h want 0", quotient_o); end
        checks++; if (remainder_o !== 32'd0) begin failures++; $display("FAIL reset_rem: got %h want 0", remainder_o); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_divu_basic();
        int lat, st; logic [W-1:0] q, r; bit got;
        run_div(1'b0, 32'd100, 32'd7, lat, st, q, r, got);
        checks++; if (!got) begin failures++; $display("FAIL divu_timeout: no ready_o within 100 cycles"); end
        checks++; if (lat != 33) begin failures++; $display("FAIL divu_latency: got %0d want 33", lat); end
        checks++; if (st != 33) begin failures++; $display("FAIL divu_stall_cycles: got %0d want 33", st); end
        checks++; if (q !== 32'd14) begin failures++; $display("FAIL divu_quo: got %h want 0000000e", q); end
        checks++; if (r !== 32'd2) begin failures++; $display("FAIL divu_rem: got %h want 00000002", r); end
        last_q = 32'd14; last_r = 32'd2;
        go_idle();
        #1;
        checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL ready_one_cycle: got %b want 0", ready_o); end
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL idle_stall: got %b want 0", stallreq_o); end
    endtask

    task automatic test_signed();
        int lat, st; logic [W-1:0] q, r; bit got;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, st, q, r, got);
        checks++; if (!got || q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL div_neg7_2: got q=%h r=%h want q=fffffffd r=ffffffff", q, r); end
        go_idle();
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, st, q, r, got);
        checks++; if (!got || q !== 32'hFFFF_FFFD || r !== 32'd1) begin
            failures++; $display("FAIL div_7_neg2: got q=%h r=%h want q=fffffffd r=00000001", q, r); end
        last_q = 32'hFFFF_FFFD; last_r = 32'd1;
        go_idle();
    endtask

    task automatic test_div_zero();
        int lat, st; logic [W-1:0] q, r; bit got;
        run_div(1'b1, 32'h1234_5678, 32'd0, lat, st, q, r, got);
        checks++; if (!got || lat != 2) begin failures++; $display("FAIL dz_latency: got %0d want 2", lat); end
        checks++; if (st != 2) begin failures++; $display("FAIL dz_stall_cycles: got %0d want 2", st); end
        checks++; if (q !== 32'd0 || r !== 32'd0) begin
            failures++; $display("FAIL dz_result: got q=%h r=%h want 0 0", q, r); end
        last_q = 32'd0; last_r = 32'd0;
        go_idle();
        // Give the output registers a non-zero history so the annul test can see them held.
        run_div(1'b0, 32'd1000, 32'd3, lat, st, q, r, got);
        last_q = 32'd333; last_r = 32'd1;
        checks++; if (q !== last_q || r !== last_r) begin
            failures++; $display("FAIL divu_1000_3: got q=%h r=%h want 0000014d 00000001", q, r); end
        go_idle();
    endtask

    task automatic test_annul();
        bit seen = 1'b0;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0;
        dividend_i = $urandom; divisor_i = $urandom | 32'd1;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        annul_i = 1'b1;
        #1;
        checks++; if (stallreq_o !== 1'b0) begin failures++; $display("FAIL annul_stall_drop: got %b want 0", stallreq_o); end
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (ready_o) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin failures++; $display("FAIL annul_no_ready: got ready pulse want none"); end
        checks++; if (quotient_o !== last_q || remainder_o !== last_r) begin
            failures++; $display("FAIL annul_hold: got q=%h r=%h want q=%h r=%h", quotient_o, remainder_o, last_q, last_r); end
    endtask

    task automatic test_reset_mid();
        int lat, st; logic [W-1:0] q, r; bit got;
        @(negedge clk);
        start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'hDEAD_BEEF; divisor_i = 32'd5;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (ready_o !== 1'b0 || stallreq_o !== 1'b0 || quotient_o !== 32'd0 || remainder_o !== 32'd0) begin
            failures++; $display("FAIL rst_mid_outputs: got rdy=%b stall=%b q=%h r=%h want all 0",
                                 ready_o, stallreq_o, quotient_o, remainder_o); end
        @(negedge clk);
        rst = 1'b0;
        run_div(1'b0, 32'd9, 32'd3, lat, st, q, r, got);
        checks++; if (!got || lat != 33 || q !== 32'd3 || r !== 32'd0) begin
            failures++; $display("FAIL rst_mid_then_9_3: got lat=%0d q=%h r=%h want lat=33 q=3 r=0", lat, q, r); end
        last_q = 32'd3; last_r = 32'd0;
        go_idle();
    endtask

    task automatic test_back_to_back();
        int lat, st; logic [W-1:0] q, r; bit got;
        run_div(1'b0, 32'hFFFF_FFFF, 32'd16, lat, st, q, r, got);
        checks++; if (!got || q !== 32'h0FFF_FFFF || r !== 32'hF) begin
            failures++; $display("FAIL b2b_first: got q=%h r=%h want 0fffffff 0000000f", q, r); end
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, st, q, r, got);
        checks++; if (!got || lat != 33 || st != 33) begin
            failures++; $display("FAIL b2b_second_timing: got lat=%0d stalls=%0d want 33 33", lat, st); end
        checks++; if (q !== 32'h8000_0000 || r !== 32'd0) begin
            failures++; $display("FAIL b2b_overflow: got q=%h r=%h want 80000000 00000000", q, r); end
        last_q = 32'h8000_0000; last_r = 32'd0;
        go_idle();
    endtask

    task automatic test_random();
        int lat, st; logic [W-1:0] q, r, eq, er, a, b; bit got, sg;
        for (int i = 0; i < 24; i++) begin
            sg = $urandom_range(0, 1);
            a  = $urandom;
            case (i % 4)
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 255);
                2:       b = 32'hFFFF_FF00 | $urandom_range(0, 255);
                default: b = $urandom;
            endcase
            model(sg, a, b, eq, er);
            run_div(sg, a, b, lat, st, q, r, got);
            checks++; if (!got || lat != ((b == 32'd0) ? 2 : 33) || q !== eq || r !== er) begin
                failures++; $display("FAIL rand_%0d: s=%b %h/%h got lat=%0d q=%h r=%h want q=%h r=%h",
                                     i, sg, a, b, lat, q, r, eq, er); end
            last_q = eq; last_r = er;
            if ($urandom_range(0, 1) == 0) go_idle();
        end
        go_idle();
        repeat (3) @(negedge clk);
        #1;
        checks++; if (quotient_o !== last_q || remainder_o !== last_r) begin
            failures++; $display("FAIL hold_between: got q=%h r=%h want q=%h r=%h", quotient_o, remainder_o, last_q, last_r); end
    endtask

    initial begin
        test_reset();
        test_divu_basic();
        test_signed();
        test_div_zero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
